star_arb_pkt_fifo: RTL and testbench



---
 rtl/star_arb_pkt_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_star_arb_pkt_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_arb_pkt_fifo.sv
// -----------------------------------------------------------------------------
// star_arb_pkt_fifo
//
// Store-and-forward packet FIFO placed after the last star arbiter of a chain.
// Incoming AXI Stream words are buffered and only become visible downstream
// once their packet's TLAST has been accepted. A committed packet therefore
// drains without gaps, and a stalled consumer never sees a partial packet.
//
// Optional feature macro: STAR_ARB_PKT_DROP_EN
//   undefined : backpressure on src_TREADY when full, with deadlock release
//               for packets larger than the buffer; drop_count tied to 0.
//   defined   : src_TREADY held high after reset; a packet that overflows
//               the buffer is discarded and counted in drop_count.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset (deassert synchronously to clk)
//   src_T*      input stream from the arbiter chain (TDATA/TVALID/TREADY/TLAST)
//   res_T*      output stream, driven from a one-word output register
//   pkt_count   complete packets held, including one partly drained
//   drop_count  packets discarded, saturating at 255
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module star_arb_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_TDATA,
  input  logic                  src_TVALID,
  output logic                  src_TREADY,
  input  logic                  src_TLAST,
  output logic [DATA_WIDTH-1:0] res_TDATA,
  output logic                  res_TVALID,
  input  logic                  res_TREADY,
  output logic                  res_TLAST,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic [7:0]            drop_count
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]         PTR_DEPTH = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   PKT_ONE   = PW'(1);

  // Storage: {TLAST, TDATA} per entry
  logic [DATA_WIDTH:0] mem_r [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] commit_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW-1:0] commit_ptr_nxt_s;
  logic [PW-1:0] wr_ptr_inc_s;
  logic [PW-1:0] occ_s;

  logic                  ready_en_r;
  logic                  full_s;
  logic                  src_ready_s;
  logic                  wr_acc_s;
  logic                  store_s;
  logic                  load_s;
  logic                  out_xfer_s;
  logic                  pkt_inc_s;
  logic                  pkt_dec_s;
  logic                  res_valid_r;
  logic                  res_last_r;
  logic [DATA_WIDTH-1:0] res_data_r;
  logic [ADDR_WIDTH:0]   pkt_count_r;

`ifdef STAR_ARB_PKT_DROP_EN
  logic       drop_flag_r;
  logic       drop_flag_nxt_s;
  logic       drop_word_s;
  logic       drop_end_s;
  logic [7:0] drop_count_r;
`else
  logic       release_s;
`endif

  // Occupancy, full flag and incremented write pointer
  always_comb begin
    occ_s        = wr_ptr_r - rd_ptr_r;
    full_s       = (occ_s == PTR_DEPTH);
    wr_ptr_inc_s = wr_ptr_r + PTR_ONE;
  end

`ifdef STAR_ARB_PKT_DROP_EN
  // Input acceptance: always ready; overflowing packets are discarded word by word
  always_comb begin
    src_ready_s = ready_en_r;
    wr_acc_s    = src_TVALID && src_ready_s;
    drop_word_s = wr_acc_s && (full_s || drop_flag_r);
    drop_end_s  = drop_word_s && src_TLAST;
    store_s     = wr_acc_s && !drop_word_s;
  end
`else
  // Input acceptance: backpressure when full; release a packet too big to fit
  always_comb begin
    src_ready_s = ready_en_r && !full_s;
    wr_acc_s    = src_TVALID && src_ready_s;
    store_s     = wr_acc_s;
    // Buffer full of one uncommitted packet: nothing can ever drain unless
    // the buffered words are released as a cut-through fragment.
    release_s   = full_s && (commit_ptr_r == rd_ptr_r);
  end
`endif

  // Read side and packet-count events
  always_comb begin
    out_xfer_s = res_valid_r && res_TREADY;
    load_s     = (!res_valid_r || res_TREADY) && (rd_ptr_r != commit_ptr_r);
    pkt_inc_s  = store_s && src_TLAST;
    pkt_dec_s  = out_xfer_s && res_last_r;
  end

  // Next-state values for the write and commit pointers
  always_comb begin
    wr_ptr_nxt_s     = wr_ptr_r;
    commit_ptr_nxt_s = commit_ptr_r;
    if (store_s) begin
      wr_ptr_nxt_s = wr_ptr_inc_s;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
`ifdef STAR_ARB_PKT_DROP_EN
    drop_flag_nxt_s = drop_flag_r;
    if (pkt_inc_s) begin
      commit_ptr_nxt_s = wr_ptr_inc_s;
    end else begin
      commit_ptr_nxt_s = commit_ptr_r;
    end
    // Dropped packet complete: forget any of its words already stored
    if (drop_end_s) begin
      wr_ptr_nxt_s    = commit_ptr_r;
      drop_flag_nxt_s = 1'b0;
    end else if (drop_word_s) begin
      drop_flag_nxt_s = 1'b1;
    end else begin
      drop_flag_nxt_s = drop_flag_r;
    end
`else
    if (pkt_inc_s) begin
      commit_ptr_nxt_s = wr_ptr_inc_s;
    end else if (release_s) begin
      commit_ptr_nxt_s = wr_ptr_r;
    end else begin
      commit_ptr_nxt_s = commit_ptr_r;
    end
`endif
  end

  // Buffer write port (data array needs no reset: reads only follow commits)
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= {src_TLAST, src_TDATA};
    end
  end

  // Pointers, output register and packet counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_r   <= 1'b0;
      wr_ptr_r     <= {PW{1'b0}};
      commit_ptr_r <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      res_valid_r  <= 1'b0;
      res_last_r   <= 1'b0;
      res_data_r   <= {DATA_WIDTH{1'b0}};
      pkt_count_r  <= {PW{1'b0}};
    end else begin
      ready_en_r   <= 1'b1;
      wr_ptr_r     <= wr_ptr_nxt_s;
      commit_ptr_r <= commit_ptr_nxt_s;
      if (load_s) begin
        rd_ptr_r                 <= rd_ptr_r + PTR_ONE;
        res_valid_r              <= 1'b1;
        {res_last_r, res_data_r} <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
      end else if (out_xfer_s) begin
        res_valid_r <= 1'b0;
      end
      case ({pkt_inc_s, pkt_dec_s})
        2'b10:   pkt_count_r <= pkt_count_r + PKT_ONE;
        2'b01:   pkt_count_r <= pkt_count_r - PKT_ONE;
        default: pkt_count_r <= pkt_count_r;
      endcase
    end
  end

`ifdef STAR_ARB_PKT_DROP_EN
  // Drop tracking: per-packet flag and saturating discard counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_flag_r  <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      drop_flag_r <= drop_flag_nxt_s;
      if (drop_end_s && (drop_count_r != 8'hFF)) begin
        drop_count_r <= drop_count_r + 8'd1;
      end
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = 8'd0;
`endif

  assign src_TREADY = src_ready_s;
  assign res_TVALID = res_valid_r;
  assign res_TDATA  = res_data_r;
  assign res_TLAST  = res_last_r;
  assign pkt_count  = pkt_count_r;

endmodule

// File: tb/tb_star_arb_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_star_arb_pkt_fifo
//
// Directed self-checking bench for star_arb_pkt_fifo (DATA_WIDTH=8,
// ADDR_WIDTH=4). Inputs are driven on the falling edge; outputs are sampled
// on the falling edge. A small queue records words the bench has handed to
// the DUT and every downstream transfer is compared against its head.
// Build-specific sections follow STAR_ARB_PKT_DROP_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_star_arb_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_TDATA;
  logic       src_TVALID;
  logic       src_TREADY;
  logic       src_TLAST;
  logic [7:0] res_TDATA;
  logic       res_TVALID;
  logic       res_TREADY;
  logic       res_TLAST;
  logic [4:0] pkt_count;
  logic [7:0] drop_count;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  bit         auto_push = 1'b1;

  star_arb_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_TDATA  (src_TDATA),
    .src_TVALID (src_TVALID),
    .src_TREADY (src_TREADY),
    .src_TLAST  (src_TLAST),
    .res_TDATA  (res_TDATA),
    .res_TVALID (res_TVALID),
    .res_TREADY (res_TREADY),
    .res_TLAST  (res_TLAST),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic l);
    src_TVALID = v;
    src_TDATA  = d;
    src_TLAST  = l;
  endtask

  // Record this cycle's handshakes, then advance to the next falling edge
  task automatic step();
    logic [8:0] e;
    if (auto_push && src_TVALID && src_TREADY) exp_q.push_back({src_TLAST, src_TDATA});
    if (res_TVALID && res_TREADY) begin
      check("out present", 32'(exp_q.size() != 0), 32'(1'b1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out word", 32'({res_TLAST, res_TDATA}), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
  endtask

  initial begin
    int  k;
    int  seq;
    int  rem;
    int  cyc;
    bit  acc;
    bit  boundary;
    bit  saw_full;

    // ---------------- reset ----------------
    rst = 1'b0;
    res_TREADY = 1'b0;
    drv(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst vld", 32'(res_TVALID), 32'(1'b0));
    check("rst data", 32'(res_TDATA), 32'(8'h00));
    check("rst last", 32'(res_TLAST), 32'(1'b0));
    check("rst pkt", 32'(pkt_count), 32'(5'd0));
    check("rst drop", 32'(drop_count), 32'(8'd0));
    check("rst rdy", 32'(src_TREADY), 32'(1'b0));
    rst = 1'b1;
    check("rdy before edge", 32'(src_TREADY), 32'(1'b0));
    step();
    check("rdy after edge", 32'(src_TREADY), 32'(1'b1));

    // ---------------- 3-word packet, latency ----------------
    res_TREADY = 1'b1;
    drv(1'b1, 8'h10, 1'b0); check("t1 vld a", 32'(res_TVALID), 32'(1'b0)); step();
    drv(1'b1, 8'h11, 1'b0); check("t1 vld b", 32'(res_TVALID), 32'(1'b0)); check("t1 pkt0", 32'(pkt_count), 32'(5'd0)); step();
    drv(1'b1, 8'h12, 1'b1); check("t1 vld c", 32'(res_TVALID), 32'(1'b0)); step();
    drv(1'b0, 8'h00, 1'b0);
    check("t1 latency", 32'(res_TVALID), 32'(1'b0));
    check("t1 pkt1", 32'(pkt_count), 32'(5'd1));
    step();
    check("t1 w0 vld", 32'(res_TVALID), 32'(1'b1));
    check("t1 w0", 32'({res_TLAST, res_TDATA}), 32'(9'h010));
    step();
    check("t1 w1 vld", 32'(res_TVALID), 32'(1'b1));
    check("t1 w1", 32'({res_TLAST, res_TDATA}), 32'(9'h011));
    step();
    check("t1 w2 vld", 32'(res_TVALID), 32'(1'b1));
    check("t1 w2", 32'({res_TLAST, res_TDATA}), 32'(9'h112));
    check("t1 pkt still1", 32'(pkt_count), 32'(5'd1));
    step();
    check("t1 idle", 32'(res_TVALID), 32'(1'b0));
    check("t1 pkt end", 32'(pkt_count), 32'(5'd0));
    check("t1 sb empty", 32'(exp_q.size()), 32'(0));

`ifndef STAR_ARB_PKT_DROP_EN
    // ---------------- stall: four 4-word packets ----------------
    // The output register pulls the first word, so the 16-entry buffer is
    // full after the 17th word (first word of a fifth packet).
    res_TREADY = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drv(1'b1, 8'(8'h20 + i), ((i % 4) == 3) && (i < 16));
      check("t2 rdy fill", 32'(src_TREADY), 32'(1'b1));
      step();
    end
    drv(1'b1, 8'h31, 1'b0);
    check("t2 full", 32'(src_TREADY), 32'(1'b0));
    check("t2 pkt4", 32'(pkt_count), 32'(5'd4));
    check("t2 head vld", 32'(res_TVALID), 32'(1'b1));
    check("t2 head", 32'(res_TDATA), 32'(8'h20));
    step();
    check("t2 still full", 32'(src_TREADY), 32'(1'b0));
    check("t2 hold", 32'({res_TLAST, res_TDATA}), 32'(9'h020));
    res_TREADY = 1'b1;
    step();
    check("t2 rdy back", 32'(src_TREADY), 32'(1'b1));
    step();
    drv(1'b1, 8'h32, 1'b0); step();
    drv(1'b1, 8'h33, 1'b1); step();
    drv(1'b0, 8'h00, 1'b0);
    drain(60);
    check("t2 sb empty", 32'(exp_q.size()), 32'(0));
    check("t2 pkt end", 32'(pkt_count), 32'(5'd0));

    // ---------------- random traffic ----------------
    seq = 0;
    rem = int'($urandom_range(6, 1));
    boundary = 1'b1;
    cyc = 0;
    while (cyc < 11000 && !(cyc >= 10000 && boundary)) begin
      if (!src_TVALID && ($urandom_range(3, 0) != 0)) begin
        drv(1'b1, 8'(seq), rem == 1);
        boundary = 1'b0;
      end
      res_TREADY = 1'($urandom_range(1, 0));
      acc = src_TVALID && src_TREADY;
      step();
      if (acc) begin
        seq++;
        if (src_TLAST) begin
          boundary = 1'b1;
          rem = int'($urandom_range(6, 1));
        end else begin
          rem--;
        end
        src_TVALID = 1'b0;
      end
      cyc++;
    end
    check("rnd tail", 32'(boundary), 32'(1'b1));
    drv(1'b0, 8'h00, 1'b0);
    res_TREADY = 1'b1;
    drain(100);
    check("rnd sb empty", 32'(exp_q.size()), 32'(0));
    check("rnd pkt end", 32'(pkt_count), 32'(5'd0));

    // ---------------- oversize packet, deadlock release ----------------
    res_TREADY = 1'b1;
    k = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 80 && !(k == 20 && exp_q.size() == 0); c++) begin
      if (k < 20) drv(1'b1, 8'(8'h40 + k), k == 19);
      else        drv(1'b0, 8'h00, 1'b0);
      if (src_TVALID && !src_TREADY) saw_full = 1'b1;
      acc = src_TVALID && src_TREADY;
      check("t4 pkt<=1", 32'(pkt_count <= 5'd1), 32'(1'b1));
      step();
      if (acc) k++;
    end
    check("t4 words in", 32'(k), 32'(20));
    check("t4 sb empty", 32'(exp_q.size()), 32'(0));
    check("t4 saw full", 32'(saw_full), 32'(1'b1));
    check("t4 pkt end", 32'(pkt_count), 32'(5'd0));
`else
    // ---------------- overflow drop ----------------
    res_TREADY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 8'(8'h60 + i), (i % 4) == 3);
      check("t5 rdy fill", 32'(src_TREADY), 32'(1'b1));
      step();
    end
    drv(1'b0, 8'h00, 1'b0);
    step();
    step();
    check("t5 pkt3", 32'(pkt_count), 32'(5'd3));
    auto_push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 8'(8'h90 + i), i == 7);
      check("t5 rdy high", 32'(src_TREADY), 32'(1'b1));
      step();
    end
    drv(1'b0, 8'h00, 1'b0);
    step();
    check("t5 drop1", 32'(drop_count), 32'(8'd1));
    check("t5 pkt same", 32'(pkt_count), 32'(5'd3));
    auto_push = 1'b1;
    res_TREADY = 1'b1;
    drain(60);
    repeat (4) step();
    check("t5 sb empty", 32'(exp_q.size()), 32'(0));
    check("t5 pkt end", 32'(pkt_count), 32'(5'd0));
    check("t5 no extra", 32'(res_TVALID), 32'(1'b0));
`endif

    // ---------------- reset mid-packet ----------------
    res_TREADY = 1'b1;
    drv(1'b1, 8'h70, 1'b0); step();
    drv(1'b1, 8'h71, 1'b0); step();
    drv(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    check("t6 vld", 32'(res_TVALID), 32'(1'b0));
    check("t6 data", 32'(res_TDATA), 32'(8'h00));
    check("t6 last", 32'(res_TLAST), 32'(1'b0));
    check("t6 pkt", 32'(pkt_count), 32'(5'd0));
    check("t6 drop", 32'(drop_count), 32'(8'd0));
    check("t6 rdy", 32'(src_TREADY), 32'(1'b0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("t6 rdy back", 32'(src_TREADY), 32'(1'b1));
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 8'(8'h80 + i), i == 2);
      check("t6 rdy pkt", 32'(src_TREADY), 32'(1'b1));
      step();
    end
    drv(1'b0, 8'h00, 1'b0);
    drain(20);
    repeat (3) step();
    check("t6 sb empty", 32'(exp_q.size()), 32'(0));
    check("t6 pkt end", 32'(pkt_count), 32'(5'd0));
    check("t6 idle", 32'(res_TVALID), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
